// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: RV32I load/store
// funct3 encodings and the transaction FSM state type.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: byte-enable generation,
// store-data lane replication and load-lane extraction with extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;

    // Pick the addressed byte and halfword out of the memory word
    always_comb begin
        byte_sel_s = 8'd0;
        case (addr_lo)
            2'd0:    byte_sel_s = rword[7:0];
            2'd1:    byte_sel_s = rword[15:8];
            2'd2:    byte_sel_s = rword[23:16];
            2'd3:    byte_sel_s = rword[31:24];
            default: byte_sel_s = 8'd0;
        endcase
        if (addr_lo[1]) begin
            half_sel_s = rword[31:16];
        end else begin
            half_sel_s = rword[15:0];
        end
    end

    // Size-dependent enables, replicated write data and extended read data
    always_comb begin
        be          = 4'b0000;
        wdata_lanes = 32'd0;
        rdata_ext   = 32'd0;
        case (funct3)
            F3_B: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{byte_sel_s[7]}}, byte_sel_s};
            end
            F3_H: begin
                if (addr_lo[1]) begin
                    be = 4'b1100;
                end else begin
                    be = 4'b0011;
                end
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{half_sel_s[15]}}, half_sel_s};
            end
            F3_W: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = rword;
            end
            F3_BU: begin
                rdata_ext = {24'd0, byte_sel_s};
            end
            F3_HU: begin
                rdata_ext = {16'd0, half_sel_s};
            end
            default: begin
                be          = 4'b0000;
                wdata_lanes = 32'd0;
                rdata_ext   = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder for an RV32I core. Loads and
// stores act on the memory at the accept edge; the response is presented
// a fixed LATENCY cycles later and held until the CPU takes it.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_32 = 32'(DEPTH_WORDS);
    // A counter load of LATENCY-1 followed by "enter RESP when it reads 0"
    // places rsp_valid exactly LATENCY cycles after accept, LATENCY==1 included.
    localparam logic [3:0]  LAT_M1   = 4'(LATENCY - 1);

    logic [31:0]   mem_r [DEPTH_WORDS];
    state_t        state_r, state_next_s;
    logic [3:0]    cnt_r, cnt_next_s;
    logic          rsp_valid_r, rsp_err_r, hold_err_r;
    logic [31:0]   rsp_rdata_r, hold_rdata_r;
    logic          accept_s, misalign_s, illegal_s, range_err_s, acc_err_s, mem_we_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   rword_s, rdata_ext_s, wdata_lanes_s;
    logic [3:0]    be_s;

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign accept_s  = req_valid && req_ready;
    assign idx_s     = req_addr[AW+1:2];

    // Classify the presented request: alignment, legality and range errors
    always_comb begin
        misalign_s = 1'b0;
        illegal_s  = 1'b0;
        case (req_funct3)
            F3_B:  misalign_s = 1'b0;
            F3_H:  misalign_s = req_addr[0];
            F3_W:  misalign_s = |req_addr[1:0];
            F3_BU: illegal_s  = req_we;
            F3_HU: begin
                illegal_s  = req_we;
                misalign_s = req_addr[0];
            end
            default: illegal_s = 1'b1;
        endcase
        range_err_s = ({2'b00, req_addr[31:2]} >= DEPTH_32);
        acc_err_s   = misalign_s || illegal_s || range_err_s;
        if (range_err_s) begin
            rword_s = 32'd0;
        end else begin
            rword_s = mem_r[idx_s];
        end
        mem_we_s = accept_s && req_we && !acc_err_s && !rst;
    end

    mem_lane_align u_align (
        .funct3      (req_funct3),
        .addr_lo     (req_addr[1:0]),
        .wdata       (req_wdata),
        .rword       (rword_s),
        .be          (be_s),
        .wdata_lanes (wdata_lanes_s),
        .rdata_ext   (rdata_ext_s)
    );

    // Byte-lane store into the memory array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_lanes_s[8*b +: 8];
                end
            end
        end
    end

    // Next-state and latency-counter logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = ST_WAIT;
                    cnt_next_s   = LAT_M1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Capture the access result at accept, publish it while in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rdata_r <= 32'd0;
            hold_err_r   <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'd0;
            rsp_err_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                hold_err_r <= acc_err_s;
                if (acc_err_s || req_we) begin
                    hold_rdata_r <= 32'd0;
                end else begin
                    hold_rdata_r <= rdata_ext_s;
                end
            end
            rsp_valid_r <= (state_next_s == ST_RESP);
            if (state_next_s != ST_RESP) begin
                rsp_rdata_r <= 32'd0;
                rsp_err_r   <= 1'b0;
            end else if (state_r != ST_RESP) begin
                rsp_rdata_r <= hold_rdata_r;
                rsp_err_r   <= hold_err_r;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency, lane handling, error
// flags, back-pressure, ignored requests and reset abort.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction starting at a negedge; response expected exactly two
    // cycles after accept, optionally held for 'stall' cycles with rsp_ready=0
    // while a stray store is presented (it must be ignored).
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int stall);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_lat1"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_lat2"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        for (int i = 0; i < stall; i++) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b010;
            req_wdata  = 32'hFFFF_FFFF;
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
            check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence
    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_funct3 = 3'b000;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        xact("sw10",  1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0);
        xact("lw10",  1'b0, 32'h10, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
        xact("lb13",  1'b0, 32'h13, 3'b000, 32'h0,         32'hFFFF_FFDE, 1'b0, 0);
        xact("lbu13", 1'b0, 32'h13, 3'b100, 32'h0,         32'h0000_00DE, 1'b0, 0);
        xact("lh10",  1'b0, 32'h10, 3'b001, 32'h0,         32'hFFFF_BEEF, 1'b0, 0);
        xact("lhu12", 1'b0, 32'h12, 3'b101, 32'h0,         32'h0000_DEAD, 1'b0, 0);
        xact("sh11",  1'b1, 32'h11, 3'b001, 32'h1234,      32'h0000_0000, 1'b1, 0);
        xact("lw10b", 1'b0, 32'h10, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
        xact("lw400", 1'b0, 32'h400, 3'b010, 32'h0,        32'h0000_0000, 1'b1, 0);
        xact("f3_011", 1'b0, 32'h10, 3'b011, 32'h0,        32'h0000_0000, 1'b1, 0);
        xact("sbu_st", 1'b1, 32'h10, 3'b100, 32'h0,        32'h0000_0000, 1'b1, 0);
        xact("lw_mis", 1'b0, 32'h12, 3'b010, 32'h0,        32'h0000_0000, 1'b1, 0);
        xact("sb11",  1'b1, 32'h11, 3'b000, 32'h0000_0055, 32'h0000_0000, 1'b0, 0);
        xact("lw10c", 1'b0, 32'h10, 3'b010, 32'h0,         32'hDEAD_55EF, 1'b0, 0);
        xact("sh12",  1'b1, 32'h12, 3'b001, 32'hAAAA_7788, 32'h0000_0000, 1'b0, 0);
        xact("lw10d", 1'b0, 32'h10, 3'b010, 32'h0,         32'h7788_55EF, 1'b0, 0);
        xact("sw3fc", 1'b1, 32'h3FC, 3'b010, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 0);
        xact("lw3fc", 1'b0, 32'h3FC, 3'b010, 32'h0,        32'h0BAD_F00D, 1'b0, 0);

        // Back-pressure for five cycles with a stray store presented
        xact("stall", 1'b0, 32'h10, 3'b010, 32'h0,         32'h7788_55EF, 1'b0, 5);
        xact("lw10e", 1'b0, 32'h10, 3'b010, 32'h0,         32'h7788_55EF, 1'b0, 0);

        // Reset during WAIT of an accepted store
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_funct3 = 3'b010;
        req_wdata  = 32'hCAFE_BABE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_wait_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_rst_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rst_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        xact("lw20", 1'b0, 32'h20, 3'b010, 32'h0, 32'hCAFE_BABE, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
